// File: rtl/piso_shift_reg_4x64.sv
// -----------------------------------------------------------------------------
// piso_shift_reg_4x64
//
// Parallel-in / serial-out word shift register for the ADC acquisition path.
// A load captures a whole bank of DEPTH words in one clock. The bank is then
// presented on dout one word per clock, highest index first.
//
// Ports
//   clk     in   1                      rising-edge clock
//   rst_n   in   1                      asynchronous active-low reset
//   load    in   1                      parallel-load strobe (wins over shifting)
//   din     in   [WIDTH-1:0] x DEPTH    word bank; din[DEPTH-1] is sent first
//   dout    out  [WIDTH-1:0]            current word, taken directly from r[DEPTH-1]
//   dvalid  out  1                      dout holds a loaded word not yet consumed
// -----------------------------------------------------------------------------
module piso_shift_reg_4x64 #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] din [DEPTH-1:0],
   output logic [WIDTH-1:0] dout,
   output logic             dvalid
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r [DEPTH-1:0];
   logic [CW-1:0]    cnt;   // words still to be presented, 0..DEPTH

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r[i] <= '0;
         cnt <= '0;
      end else if (load) begin
         for (int i = 0; i < DEPTH; i++) r[i] <= din[i];
         cnt <= CW'(DEPTH);
      end else begin
         // Zeros are shifted in at the bottom so an empty register reads 0.
         for (int i = DEPTH - 1; i > 0; i--) r[i] <= r[i-1];
         r[0] <= '0;
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   assign dout   = r[DEPTH-1];
   assign dvalid = (cnt != '0);

endmodule

// File: tb/tb_piso_shift_reg_4x64.sv
module tb_piso_shift_reg_4x64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [63:0] din [3:0];
   logic [63:0] dout;
   logic        dvalid;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q [$];

   piso_shift_reg_4x64 #(.WIDTH(64), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .din   (din),
      .dout  (dout),
      .dvalid(dvalid)
   );

   always #5 clk = ~clk;

   task automatic check_out(input string tag, input logic [63:0] ed,
                            input logic ev);
      checks++;
      assert (dout === ed) else begin
         failures++;
         $error("FAIL %s dout got=%h exp=%h", tag, dout, ed);
      end
      checks++;
      assert (dvalid === ev) else begin
         failures++;
         $error("FAIL %s dvalid got=%b exp=%b", tag, dvalid, ev);
      end
   endtask

   // One clock: update scoreboard for a load edge, then compare just after it.
   task automatic tick(input string tag);
      logic l;
      logic [63:0] w;
      l = load & rst_n;
      @(posedge clk);
      if (l) begin
         exp_q.delete();
         for (int i = 3; i >= 0; i--) exp_q.push_back(din[i]);
      end
      if (!rst_n) exp_q.delete();
      #1;
      if (exp_q.size() != 0) begin
         w = exp_q.pop_front();
         check_out(tag, w, 1'b1);
      end else begin
         check_out(tag, 64'h0, 1'b0);
      end
   endtask

   task automatic set_din(input logic [63:0] d3, input logic [63:0] d2,
                          input logic [63:0] d1, input logic [63:0] d0);
      din[3] = d3; din[2] = d2; din[1] = d1; din[0] = d0;
   endtask

   initial begin
      set_din(64'h0, 64'h0, 64'h0, 64'h0);

      // Reset held for two edges with load low
      tick("rst0");
      tick("rst1");
      @(negedge clk);
      rst_n = 1'b1;
      tick("idle0");

      // Basic load/shift; din scrambled after the load edge must not matter
      set_din(64'hA, 64'hB, 64'hC, 64'hD);
      load = 1'b1;
      tick("basic_a");
      load = 1'b0;
      set_din($urandom, $urandom, $urandom, $urandom);
      tick("basic_b");
      tick("basic_c");
      tick("basic_d");
      tick("basic_empty0");
      tick("basic_empty1");

      // Second load after idle
      for (int i = 0; i < 5; i++) tick("idle_wait");
      set_din(64'hA, 64'hB, 64'hC, 64'hD);
      load = 1'b1;
      tick("second_a");
      load = 1'b0;
      tick("second_b");
      tick("second_c");
      tick("second_d");
      tick("second_empty");

      // Reload mid-shift: C and D are dropped
      load = 1'b1;
      tick("mid_a");
      load = 1'b0;
      tick("mid_b");
      set_din(64'h1, 64'h2, 64'h3, 64'h4);
      load = 1'b1;
      tick("mid_1");
      load = 1'b0;
      tick("mid_2");
      tick("mid_3");
      tick("mid_4");
      tick("mid_empty");

      // Load held for three edges with changing din
      set_din(64'h1111_0003, 64'h1111_0002, 64'h1111_0001, 64'h1111_0000);
      load = 1'b1;
      tick("hold_1");
      set_din(64'h2222_0003, 64'h2222_0002, 64'h2222_0001, 64'h2222_0000);
      tick("hold_2");
      set_din(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
              64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001);
      tick("hold_3");
      load = 1'b0;
      tick("hold_d2");
      tick("hold_d1");
      tick("hold_d0");
      tick("hold_empty");

      // Asynchronous reset mid-shift
      set_din(64'h55, 64'h66, 64'h77, 64'h88);
      load = 1'b1;
      tick("arst_first");
      load = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_out("arst_immediate", 64'h0, 1'b0);
      tick("arst_held");
      @(negedge clk);
      rst_n = 1'b1;
      tick("arst_after0");
      tick("arst_after1");
      tick("arst_after2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      failures++;
      $display("FAIL timeout checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
